// File: rtl/disp_pkg.sv
// Shared display definitions: segment pattern type, all-off pattern, default
// scan geometry and the scan FSM state type.
package disp_pkg;

    // Segment pattern ordered {g,f,e,d,c,b,a}, active-high.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b000_0000;

    localparam int unsigned DEF_DIGITS    = 4;
    localparam int unsigned DEF_SLOT_CYC  = 1000;
    localparam int unsigned DEF_BLANK_CYC = 4;

    typedef enum logic {
        StBlank,
        StShow
    } scan_state_e;

endpackage

// File: rtl/bcd2seg0_9.sv
// BCD to 7-segment decoder for digits 0..9.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segment pattern {g,f,e,d,c,b,a}, active-high; 10..15 give all-off
module bcd2seg0_9
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a blank gap before each digit
// slot, double-buffered display value and optional leading-zero suppression.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bcd_in        4*DIGITS digit values, nibble i = digit i (digit 0 rightmost)
//   dp_in         DIGITS decimal point requests
//   load          strobe: capture bcd_in/dp_in into the pending buffer
//   lz_blank      leading-zero suppression enable, latched at frame start
//   seg, dp       registered segment/decimal-point lines, active-high
//   dig_en        registered one-hot (or all-zero) digit enables
//   frame_start   registered one-cycle pulse at the start of digit 0's slot
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS    = DEF_DIGITS,
    parameter int unsigned SLOT_CYC  = DEF_SLOT_CYC,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_start
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYC);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SLOT_CYC - BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]       pend_bcd_q, pend_bcd_d;
    logic [DIGITS-1:0]         pend_dp_q, pend_dp_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]       act_bcd_q, act_bcd_d;
    logic [DIGITS-1:0]         act_dp_q, act_dp_d;
    logic                      lz_q, lz_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [DIGITS-1:0]         dig_en_q, dig_en_d;
    logic                      frame_start_q, frame_start_d;

    logic [3:0]                cur_bcd;
    logic                      cur_dp;
    logic [DIGITS-1:0]         cur_onehot;
    logic                      lead_zero;
    logic [6:0]                dec_seg;

    // Select the current digit and find whether it and every digit to its left are zero.
    always_comb begin
        cur_bcd    = 4'd0;
        cur_dp     = 1'b0;
        cur_onehot = '0;
        lead_zero  = (idx_q != '0);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_bcd       = act_bcd_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_onehot[i] = 1'b1;
            end
            if (IDX_W'(i) >= idx_q && act_bcd_q[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
    end

    bcd2seg0_9 u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // The registered state describes the cycle about to be produced; outputs for
    // that cycle are computed here and registered alongside the state advance.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        pend_bcd_d    = pend_bcd_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        act_bcd_d     = act_bcd_q;
        act_dp_d      = act_dp_q;
        lz_d          = lz_q;
        seg_d         = SEG_OFF;
        dp_d          = 1'b0;
        dig_en_d      = '0;
        frame_start_d = 1'b0;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == '0 && idx_q == '0) begin
                    frame_start_d = 1'b1;
                    lz_d          = lz_blank;
                    if (pend_valid_q) begin
                        act_bcd_d    = pend_bcd_q;
                        act_dp_d     = pend_dp_q;
                        pend_valid_d = 1'b0;
                    end
                end
                if (cnt_q == BLANK_LAST) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                seg_d    = (lz_q && lead_zero) ? SEG_OFF : dec_seg;
                dp_d     = cur_dp;
                dig_en_d = cur_onehot;
                if (cnt_q == SHOW_LAST) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = StBlank;
        endcase

        // Placed after the frame transfer so a coincident load lands in pending
        // and waits for the next frame.
        if (load) begin
            pend_bcd_d   = bcd_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBlank;
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_bcd_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            act_bcd_q     <= '0;
            act_dp_q      <= '0;
            lz_q          <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b0;
            dig_en_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_bcd_q    <= pend_bcd_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            act_bcd_q     <= act_bcd_d;
            act_dp_q      <= act_dp_d;
            lz_q          <= lz_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_en_q      <= dig_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dig_en      = dig_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    // Reference model state: edge index since reset release and the buffers.
    int          e;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic        m_pval, m_lz;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SLOT_CYC  (SLOT),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .lz_blank    (lz_blank),
        .seg         (seg),
        .dp          (dp),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e      = 0;
        m_pend = '0;
        m_act  = '0;
        m_pdp  = '0;
        m_adp  = '0;
        m_pval = 1'b0;
        m_lz   = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then
    // compare every output just after the edge.
    task automatic step();
        int          fe, slot, pos;
        logic [15:0] above;
        logic [6:0]  s;
        logic [15:0] exp;
        @(posedge clk);
        fe   = e % FRAME;
        slot = fe / SLOT;
        pos  = fe % SLOT;
        if (fe == 0) begin
            m_lz = lz_blank;
            if (m_pval) begin
                m_act  = m_pend;
                m_adp  = m_pdp;
                m_pval = 1'b0;
            end
        end
        if (load) begin
            m_pend = bcd_in;
            m_pdp  = dp_in;
            m_pval = 1'b1;
        end
        if (pos < BLANK) begin
            exp = {3'b0, 7'b0, 1'b0, 4'b0, (fe == 0)};
        end else begin
            above = m_act >> (4 * slot);
            if (m_lz && slot != 0 && above == 16'd0) s = 7'b0;
            else s = seg_of(above[3:0]);
            exp = {3'b0, s, m_adp[slot], 4'(1 << slot), 1'b0};
        end
        #1;
        check("scan", {3'b0, seg, dp, dig_en, frame_start}, exp);
        e++;
    endtask

    // Step until the outputs of edge 'target' are visible.
    task automatic run_to(input int target);
        while (e <= target) step();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {3'b0, seg, dp, dig_en, frame_start}, 16'h0);
        rst = 1'b0;

        // Scan timing after reset release.
        run_to(0);  check("fs_cycle0", {15'b0, frame_start}, 16'h1);
        run_to(2);  check("dig0_start", {12'b0, dig_en}, 16'h1);
        run_to(7);  check("dig0_end", {12'b0, dig_en}, 16'h1);
        run_to(8);  check("gap_off", {3'b0, seg, dp, dig_en, frame_start}, 16'h0);
        run_to(10); check("dig1_start", {12'b0, dig_en}, 16'h2);
        run_to(32); check("fs_period", {15'b0, frame_start}, 16'h1);
        run_to(34); check("dig0_frame1", {12'b0, dig_en}, 16'h1);

        // Mid-frame load is deferred to the next frame.
        run_to(39);
        bcd_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
        run_to(42); check("deferred_load", {9'b0, seg}, 16'h3F);
        run_to(66); check("show_4", {9'b0, seg}, 16'h66);
        run_to(90); check("show_1", {9'b0, seg}, 16'h06);

        // Leading-zero suppression.
        run_to(69);
        bcd_in = 16'h0050; lz_blank = 1'b1; load = 1'b1; step(); load = 1'b0;
        run_to(98);  check("lz_d0", {9'b0, seg}, 16'h3F);
        run_to(106); check("lz_d1", {9'b0, seg}, 16'h6D);
        run_to(114); check("lz_d2", {5'b0, seg, dig_en}, 16'h004);
        run_to(122); check("lz_d3", {5'b0, seg, dig_en}, 16'h008);

        // Non-BCD value blanks segments but keeps the decimal point.
        run_to(129);
        lz_blank = 1'b0; bcd_in = 16'h000A; dp_in = 4'b0001; load = 1'b1; step(); load = 1'b0;
        run_to(162); check("nonbcd_dp", {8'b0, seg, dp}, 16'h001);

        // Load coinciding with the frame boundary.
        run_to(169);
        dp_in = 4'b0000; bcd_in = 16'h1111; load = 1'b1; step(); load = 1'b0;
        run_to(191);
        bcd_in = 16'h9999; load = 1'b1; step(); load = 1'b0;
        run_to(194); check("boundary_old", {9'b0, seg}, 16'h06);
        run_to(226); check("boundary_new", {9'b0, seg}, 16'h6F);

        // Asynchronous reset during digit 2's slot discards a pending load.
        run_to(259);
        bcd_in = 16'h4321; load = 1'b1; step(); load = 1'b0;
        run_to(275); check("pre_rst_dig2", {12'b0, dig_en}, 16'h4);
        #2 rst = 1'b1;
        #1 check("rst_async", {3'b0, seg, dp, dig_en, frame_start}, 16'h0);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", {3'b0, seg, dp, dig_en, frame_start}, 16'h0);
        rst = 1'b0;
        model_reset();
        run_to(0); check("rst_fs", {15'b0, frame_start}, 16'h1);
        run_to(2); check("rst_zero_d0", {5'b0, seg, dig_en}, {5'b0, 7'h3F, 4'h1});
        run_to(40);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            bcd_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            lz_blank = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bcd_in[15:8] = 8'h00;
            step();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
